// File: rtl/pad_share_arbiter.sv
// pad_share_arbiter: round-robin sharing of one registered pad bundle among NREQ requesters,
// with released pads for GAP cycles between owners. Define PAD_SHARE_PREEMPT_EN for hold-limit preemption.
`timescale 1ns/1ps
module pad_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16,
    parameter int GAP      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ-1:0]         req_oe,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic [DW-1:0]           pad_do,
    output logic                    pad_oe,
    input  logic [DW-1:0]           pad_di,
    output logic [DW-1:0]           rx_data
);
    localparam int OW = $clog2(NREQ);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [GW-1:0]   GAP_V     = GW'(GAP);
    localparam logic [OW-1:0]   OWNER_RST = OW'(NREQ - 1);
    localparam logic [NREQ-1:0] GNT_ONE   = NREQ'(1);

    if (NREQ < 2 || NREQ > 8 || GAP < 1 || MAX_HOLD < 1) begin : g_bad_param
        $error("pad_share_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

    state_t          state_reg, state_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [DW-1:0]   pad_do_reg, pad_do_next;
    logic            pad_oe_reg, pad_oe_next;
    logic [DW-1:0]   rx_data_reg;
    logic [OW-1:0]   winner;
    logic            release_now;
`ifdef PAD_SHARE_PREEMPT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX_V = HW'(MAX_HOLD);
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
`endif

    logic [DW-1:0] data_arr [NREQ];
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign data_arr[gi] = req_data[gi*DW +: DW];
    end

    // Search starts one past the last owner, so the last owner itself is checked last.
    always_comb begin
        int            idx_full;
        logic          found;
        logic [OW-1:0] idx;
        winner   = owner_reg;
        found    = 1'b0;
        idx_full = 0;
        idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_full = (int'(owner_reg) + k) % NREQ;
            idx      = idx_full[OW-1:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= '0;
            owner_reg    <= OWNER_RST;
            gap_cnt_reg  <= '0;
            pad_do_reg   <= '0;
            pad_oe_reg   <= 1'b0;
            rx_data_reg  <= '0;
`ifdef PAD_SHARE_PREEMPT_EN
            hold_cnt_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            owner_reg    <= owner_next;
            gap_cnt_reg  <= gap_cnt_next;
            pad_do_reg   <= pad_do_next;
            pad_oe_reg   <= pad_oe_next;
            rx_data_reg  <= pad_di;
`ifdef PAD_SHARE_PREEMPT_EN
            hold_cnt_reg <= hold_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        owner_next   = owner_reg;
        gap_cnt_next = gap_cnt_reg;
        pad_do_next  = '0;
        pad_oe_next  = 1'b0;
        release_now  = 1'b0;
`ifdef PAD_SHARE_PREEMPT_EN
        hold_cnt_next = hold_cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    state_next = ST_GRANT;
                    gnt_next   = GNT_ONE << winner;
                    owner_next = winner;
`ifdef PAD_SHARE_PREEMPT_EN
                    hold_cnt_next = HW'(1);
`endif
                end
            end
            ST_GRANT: begin
                release_now = !req[owner_reg];
`ifdef PAD_SHARE_PREEMPT_EN
                // gnt_reg is the owner's one-hot, so this masks out the owner's own request.
                if (hold_cnt_reg == HOLD_MAX_V && |(req & ~gnt_reg)) begin
                    release_now = 1'b1;
                end
`endif
                if (release_now) begin
                    state_next   = ST_TURN;
                    gnt_next     = '0;
                    gap_cnt_next = GW'(1);
                end else begin
                    pad_do_next = data_arr[owner_reg];
                    pad_oe_next = req_oe[owner_reg];
`ifdef PAD_SHARE_PREEMPT_EN
                    if (hold_cnt_reg != HOLD_MAX_V) begin
                        hold_cnt_next = hold_cnt_reg + HW'(1);
                    end
`endif
                end
            end
            ST_TURN: begin
                if (gap_cnt_reg == GAP_V) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign gnt     = gnt_reg;
    assign owner   = owner_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign pad_do  = pad_do_reg;
    assign pad_oe  = pad_oe_reg;
    assign rx_data = rx_data_reg;
endmodule

// File: tb/tb_pad_share_arbiter.sv
// Testbench for pad_share_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic against a cycle-level reference model of the sharing rules.
`timescale 1ns/1ps
module tb_pad_share_arbiter;
    localparam int NREQ = 4, DW = 8, MAX_HOLD = 16, GAP = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ-1:0]     req_oe = '0;
    logic [NREQ-1:0]     gnt;
    logic [1:0]          owner;
    logic                busy;
    logic [DW-1:0]       pad_do;
    logic                pad_oe;
    logic [DW-1:0]       pad_di = '0;
    logic [DW-1:0]       rx_data;

    int n_tests = 0;
    int n_fail  = 0;

    pad_share_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_HOLD(MAX_HOLD), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_oe(req_oe),
        .gnt(gnt), .owner(owner), .busy(busy), .pad_do(pad_do), .pad_oe(pad_oe),
        .pad_di(pad_di), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the pads, how many released cycles remain, how long held.
    bit            m_granted;
    int            m_owner, m_turn, m_hold;
    logic [DW-1:0] e_do, e_rx;
    logic          e_oe;

    task automatic model_reset();
        m_granted = 0; m_owner = NREQ - 1; m_turn = 0; m_hold = 0;
        e_do = '0; e_oe = 1'b0; e_rx = '0;
    endtask

    task automatic model_edge();
        bit rel, found;
        e_rx = pad_di;
        if (m_granted) begin
            rel = !req[m_owner];
`ifdef PAD_SHARE_PREEMPT_EN
            if (m_hold == MAX_HOLD && (req & ~(NREQ'(1) << m_owner)) != 0) rel = 1;
`endif
            if (rel) begin
                m_granted = 0; m_turn = GAP; e_do = '0; e_oe = 1'b0;
            end else begin
                e_do = req_data[m_owner*DW +: DW];
                e_oe = req_oe[m_owner];
                if (m_hold < MAX_HOLD) m_hold++;
            end
        end else begin
            e_do = '0; e_oe = 1'b0;
            if (m_turn > 0) begin
                m_turn--;
            end else if (req != 0) begin
                found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && req[(m_owner + k) % NREQ]) begin
                        m_owner = (m_owner + k) % NREQ;
                        found = 1;
                    end
                end
                m_granted = 1; m_hold = 1;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [NREQ-1:0] e_gnt;
        logic            e_busy;
        e_gnt  = m_granted ? (NREQ'(1) << m_owner) : '0;
        e_busy = m_granted || (m_turn > 0);
        n_tests++;
        if ({gnt, owner, busy, pad_do, pad_oe, rx_data} !==
            {e_gnt, 2'(m_owner), e_busy, e_do, e_oe, e_rx}) begin
            n_fail++;
            $display("FAIL model t=%0t: gnt=%b/%b owner=%0d/%0d busy=%b/%b pad_do=%h/%h pad_oe=%b/%b rx=%h/%h (got/expected)",
                     $time, gnt, e_gnt, owner, m_owner, busy, e_busy, pad_do, e_do, pad_oe, e_oe, rx_data, e_rx);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic reset_dut();
        req = '0; req_oe = '0; req_data = '0; pad_di = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_state", {gnt, owner, busy, pad_do, pad_oe, rx_data},
            {4'b0000, 2'd3, 1'b0, 8'h00, 1'b0, 8'h00});
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] oe;
        logic [7:0] di;
        logic [3:0] gnt;
        logic [1:0] own;
        logic       busy;
        logic [7:0] pdo;
        logic       poe;
    } vec_t;
    vec_t vt[13];

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int hc, lc, w, tcnt;

        vt[0]  = '{4'b0100, 4'b0100, 8'h3C, 4'b0100, 2'd2, 1'b1, 8'h00, 1'b0};
        vt[1]  = '{4'b0100, 4'b0100, 8'hC3, 4'b0100, 2'd2, 1'b1, 8'hA5, 1'b1};
        vt[2]  = '{4'b0110, 4'b0110, 8'h5A, 4'b0100, 2'd2, 1'b1, 8'hA5, 1'b1};
        vt[3]  = '{4'b0010, 4'b0110, 8'h00, 4'b0000, 2'd2, 1'b1, 8'h00, 1'b0};
        vt[4]  = '{4'b0010, 4'b0110, 8'hFF, 4'b0000, 2'd2, 1'b1, 8'h00, 1'b0};
        vt[5]  = '{4'b0010, 4'b0110, 8'h01, 4'b0000, 2'd2, 1'b0, 8'h00, 1'b0};
        vt[6]  = '{4'b0010, 4'b0000, 8'h02, 4'b0010, 2'd1, 1'b1, 8'h00, 1'b0};
        vt[7]  = '{4'b0010, 4'b0000, 8'h04, 4'b0010, 2'd1, 1'b1, 8'h22, 1'b0};
        vt[8]  = '{4'b0010, 4'b0010, 8'h08, 4'b0010, 2'd1, 1'b1, 8'h22, 1'b1};
        vt[9]  = '{4'b0000, 4'b0010, 8'h10, 4'b0000, 2'd1, 1'b1, 8'h00, 1'b0};
        vt[10] = '{4'b1000, 4'b1000, 8'h20, 4'b0000, 2'd1, 1'b1, 8'h00, 1'b0};
        vt[11] = '{4'b0000, 4'b0000, 8'h40, 4'b0000, 2'd1, 1'b0, 8'h00, 1'b0};
        vt[12] = '{4'b0000, 4'b0000, 8'h80, 4'b0000, 2'd1, 1'b0, 8'h00, 1'b0};

        reset_dut();

        // Directed vectors: grant, pad latency, isolation, release, gap, ignored request in turn.
        req_data = 32'h44A5_2211;
        for (int i = 0; i < 13; i++) begin
            req = vt[i].req; req_oe = vt[i].oe; pad_di = vt[i].di;
            tick();
            cmp($sformatf("vec%0d", i), {gnt, owner, busy, pad_do, pad_oe, rx_data},
                {vt[i].gnt, vt[i].own, vt[i].busy, vt[i].pdo, vt[i].poe, vt[i].di});
        end

        // Isolation: requester 0 owns while the others churn their data and enables.
        req = 4'b0001; req_oe = 4'b0001; req_data = 32'h0000_005E;
        tick();
        cmp("iso_grant", gnt, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            req_data[31:8] = 24'($urandom);
            req_oe[3:1]    = 3'($urandom);
            req[3:1]       = (i == 0) ? 3'b000 : 3'($urandom);
            pad_di         = (i == 3) ? 8'h3C : 8'($urandom);
            tick();
            cmp("iso_pad", {pad_do, pad_oe}, {8'h5E, 1'b1});
            if (i == 3) cmp("rx_data", rx_data, 8'h3C);
        end
        req = '0;
        repeat (4) tick();

        // Hold limit with a competing request arriving during grant cycle 5.
        req = 4'b0001; req_oe = 4'b0001;
        tick();
        cmp("hold_grant", gnt, 4'b0001);
        hc = 1;
        while (gnt[0] && hc < 40) begin
            if (hc == 5) req = 4'b0011;
            tick();
            if (gnt[0]) hc++;
        end
`ifdef PAD_SHARE_PREEMPT_EN
        cmp("hold_cycles", hc, MAX_HOLD);
`else
        cmp("hold_cycles", hc, 40);
        req = 4'b0010;
        tick();
`endif
        lc = 1;
        while (gnt != 4'b0010 && lc < 10) begin
            tick();
            if (gnt == 0) lc++;
        end
        cmp("handover_gap", lc, GAP + 1);
        cmp("handover_gnt", gnt, 4'b0010);

        // Round robin with all requesters active, each owner releasing after 3 cycles.
        reset_dut();
        tcnt = 0;
        for (int n = 0; n < 5; n++) begin
            req = 4'b1111;
            w = 0;
            while (gnt == 0 && w < 20) begin
                tick();
                w++;
                if (gnt == 0 && busy) tcnt++;
            end
            cmp("rr_wait", gnt != 0, 1'b1);
            cmp($sformatf("rr_order%0d", n), owner, exp_order[n]);
            if (n > 0) cmp("rr_turn_cycles", tcnt, GAP);
            tick(); tick();
            req = 4'b1111 & ~gnt;
            tick();
            tcnt = (gnt == 0 && busy) ? 1 : 0;
        end

        // Randomized traffic against the reference model.
        reset_dut();
        for (int c = 0; c < 1500; c++) begin
            req      = req ^ 4'($urandom & $urandom & $urandom);
            req_oe   = 4'($urandom);
            req_data = $urandom;
            pad_di   = 8'($urandom);
            tick();
        end

        // Asynchronous reset in the middle of a grant, checked with no clock edge.
        reset_dut();
        req = 4'b0001; req_oe = 4'b0001; req_data = 32'h0000_00E7;
        tick(); tick();
        cmp("pre_reset_pad", {gnt, pad_do, pad_oe}, {4'b0001, 8'hE7, 1'b1});
        #2;
        rst = 1'b1;
        #1;
        cmp("async_reset", {gnt, owner, busy, pad_do, pad_oe}, {4'b0000, 2'd3, 1'b0, 8'h00, 1'b0});
        reset_dut();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
